// File: rtl/rocket_flight_unit.sv
// -----------------------------------------------------------------------------
// rocket_flight_unit
//
// Per-rocket motion stage. A rising edge on launchReq while idle latches the
// launch X, Y and vertical speed. While flying, Y advances once per frame
// in FRAC_BITS fixed point. The rocket retires on a collision or when it
// leaves the screen vertically.
//
// Optional feature macro: ROCKET_EXPLOSION_EN
//   Defined   : a collision moves the rocket to EXPLODING. explodeActive is
//               high for EXPLODE_FRAMES frames, and the position is frozen
//               during that time.
//   Undefined : a collision returns the rocket directly to IDLE, and
//               explodeActive is tied to 0.
//
// Ports
//   clk           in   1   system clock
//   resetN        in   1   asynchronous active-low reset
//   launchReq     in   1   launch request level; its rising edge is a launch
//   initialSpeed  in   9   signed speed, pixel/64 per frame (negative = up)
//   initialX      in   11  signed launch top-left X
//   initialY      in   11  signed launch top-left Y
//   startOfFrame  in   1   one-cycle pulse per frame
//   collision     in   1   rocket hit something (level)
//   topLeftX      out  11  signed current top-left X (registered)
//   topLeftY      out  11  signed current top-left Y, integer part (registered)
//   isActive      out  1   rocket in flight (registered)
//   launchAck     out  1   one-cycle pulse when a launch is accepted
//   explodeActive out  1   explosion sprite enable
// -----------------------------------------------------------------------------
module rocket_flight_unit #(
  parameter int FRAC_BITS       = 6,
  parameter int SCREEN_TOP_Y    = 0,
  parameter int SCREEN_BOTTOM_Y = 479,
  parameter int ROCKET_HEIGHT   = 16,
  parameter int EXPLODE_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               launchReq,
  input  logic signed [8:0]  initialSpeed,
  input  logic signed [10:0] initialX,
  input  logic signed [10:0] initialY,
  input  logic               startOfFrame,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               isActive,
  output logic               launchAck,
  output logic               explodeActive
);

  localparam int Y_W = 11 + FRAC_BITS;
  localparam logic signed [10:0] TOP_LIMIT    = 11'(SCREEN_TOP_Y - ROCKET_HEIGHT);
  localparam logic signed [10:0] BOTTOM_LIMIT = 11'(SCREEN_BOTTOM_Y);

  // Reject parameter sets that the fixed-point layout cannot represent.
  if (FRAC_BITS < 1 || EXPLODE_FRAMES < 1) begin : g_bad_cfg
    $error("rocket_flight_unit: FRAC_BITS and EXPLODE_FRAMES must be >= 1");
  end

`ifdef ROCKET_EXPLOSION_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1, EXPLODING = 2'd2} state_t;
  localparam int CNT_W = $clog2(EXPLODE_FRAMES + 1);
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             explode_r, explode_n;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1} state_t;
`endif

  state_t                 state_r, state_n;
  logic                   launch_d_r;
  logic                   armed_r;
  logic signed [Y_W-1:0]  y_fx_r, y_fx_n;
  logic signed [8:0]      speed_r, speed_n;
  logic signed [10:0]     x_r, x_n;
  logic signed [10:0]     y_out_r, y_out_n;
  logic                   active_r, active_n;
  logic                   ack_r, ack_n;

  logic                   launch_edge_s;
  logic signed [Y_W-1:0]  y_sum_s;
  logic signed [10:0]     y_sum_int_s;
  logic                   exit_s;

  // armed_r only rises once launchReq has been seen low after reset. A
  // request held high through reset release is therefore not taken as a
  // launch until it falls and rises again.
  assign launch_edge_s = launchReq & ~launch_d_r & armed_r;

  // Per-frame Y step. Slicing off the fraction bits is an arithmetic floor.
  assign y_sum_s     = y_fx_r + {{(Y_W-9){speed_r[8]}}, speed_r};
  assign y_sum_int_s = y_sum_s[Y_W-1:FRAC_BITS];
  assign exit_s      = (y_sum_int_s < TOP_LIMIT) || (y_sum_int_s > BOTTOM_LIMIT);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      launch_d_r <= 1'b0;
      armed_r    <= 1'b0;
      y_fx_r     <= '0;
      speed_r    <= 9'sd0;
      x_r        <= 11'sd0;
      y_out_r    <= 11'sd0;
      active_r   <= 1'b0;
      ack_r      <= 1'b0;
`ifdef ROCKET_EXPLOSION_EN
      cnt_r      <= '0;
      explode_r  <= 1'b0;
`endif
    end else begin
      state_r    <= state_n;
      launch_d_r <= launchReq;
      armed_r    <= armed_r | ~launchReq;
      y_fx_r     <= y_fx_n;
      speed_r    <= speed_n;
      x_r        <= x_n;
      y_out_r    <= y_out_n;
      active_r   <= active_n;
      ack_r      <= ack_n;
`ifdef ROCKET_EXPLOSION_EN
      cnt_r      <= cnt_n;
      explode_r  <= explode_n;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_r;
    y_fx_n    = y_fx_r;
    speed_n   = speed_r;
    x_n       = x_r;
    y_out_n   = y_out_r;
    active_n  = active_r;
    ack_n     = 1'b0;
`ifdef ROCKET_EXPLOSION_EN
    cnt_n     = cnt_r;
    explode_n = explode_r;
`endif
    case (state_r)
      IDLE: begin
        if (launch_edge_s) begin
          state_n  = FLYING;
          x_n      = initialX;
          speed_n  = initialSpeed;
          y_fx_n   = {initialY, {FRAC_BITS{1'b0}}};
          y_out_n  = initialY;
          active_n = 1'b1;
          ack_n    = 1'b1;
        end else begin
          active_n = 1'b0;
        end
      end
      FLYING: begin
        // Collision wins over a coincident frame pulse; Y stays put.
        if (collision) begin
          active_n  = 1'b0;
`ifdef ROCKET_EXPLOSION_EN
          state_n   = EXPLODING;
          explode_n = 1'b1;
          cnt_n     = '0;
`else
          state_n   = IDLE;
`endif
        end else if (startOfFrame) begin
          y_fx_n  = y_sum_s;
          y_out_n = y_sum_int_s;
          if (exit_s) begin
            state_n  = IDLE;
            active_n = 1'b0;
          end else begin
            active_n = 1'b1;
          end
        end else begin
          active_n = 1'b1;
        end
      end
`ifdef ROCKET_EXPLOSION_EN
      EXPLODING: begin
        if (startOfFrame) begin
          if (cnt_r == CNT_W'(EXPLODE_FRAMES - 1)) begin
            state_n   = IDLE;
            explode_n = 1'b0;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
`endif
      default: begin
        state_n  = IDLE;
        active_n = 1'b0;
      end
    endcase
  end

  assign topLeftX  = x_r;
  assign topLeftY  = y_out_r;
  assign isActive  = active_r;
  assign launchAck = ack_r;
`ifdef ROCKET_EXPLOSION_EN
  assign explodeActive = explode_r;
`else
  assign explodeActive = 1'b0;
`endif

endmodule

// File: tb/tb_rocket_flight_unit.sv
// -----------------------------------------------------------------------------
// tb_rocket_flight_unit
//
// Table-driven flight vectors with expected results queued on a scoreboard,
// plus hand-written sequences for collision priority, ignored launches and
// reset in mid-flight.
// -----------------------------------------------------------------------------
module tb_rocket_flight_unit;

  logic               clk = 1'b0;
  logic               resetN;
  logic               launchReq;
  logic signed [8:0]  initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic               startOfFrame;
  logic               collision;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               isActive;
  logic               launchAck;
  logic               explodeActive;

  int n_checks = 0;
  int n_fail   = 0;

  rocket_flight_unit dut (
    .clk          (clk),
    .resetN       (resetN),
    .launchReq    (launchReq),
    .initialSpeed (initialSpeed),
    .initialX     (initialX),
    .initialY     (initialY),
    .startOfFrame (startOfFrame),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .isActive     (isActive),
    .launchAck    (launchAck),
    .explodeActive(explodeActive)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    x0;
    int    y0;
    int    spd;
    int    sofs;
    int    exp_y;
    int    exp_act;
  } vec_t;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    act;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic launch(input int x, input int y, input int spd);
    initialX     = 11'(x);
    initialY     = 11'(y);
    initialSpeed = 9'(spd);
    launchReq    = 1'b0;
    tick();
    launchReq    = 1'b1;
    tick();
  endtask

  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  // Bring the unit back to IDLE between vectors.
  task automatic retire();
    if (isActive) begin
      collision = 1'b1;
      tick();
      collision = 1'b0;
`ifdef ROCKET_EXPLOSION_EN
      sof(8);
`endif
    end
    launchReq = 1'b0;
    tick();
  endtask

  initial begin
    exp_t e;

    //          name            x0    y0   spd  sofs exp_y act
    vecs[0]  = '{"up_1sof",     300,  400, -128,   1,  398, 1};
    vecs[1]  = '{"up_208sof",   300,  400, -128, 208,  -16, 1};
    vecs[2]  = '{"up_exit",     300,  400, -128, 209,  -18, 0};
    vecs[3]  = '{"down_1sof",    20,  470,   64,   1,  471, 1};
    vecs[4]  = '{"down_9sof",    20,  470,   64,   9,  479, 1};
    vecs[5]  = '{"down_exit",    20,  470,   64,  10,  480, 0};
    vecs[6]  = '{"frac_64sof",  -50,  100,   -1,  64,   99, 1};
    vecs[7]  = '{"frac_65sof",  -50,  100,   -1,  65,   98, 1};
    vecs[8]  = '{"stationary",  639,  200,    0,  50,  200, 1};
    vecs[9]  = '{"neg_floor",   -20,  -10,    3,   5,  -10, 1};
    vecs[10] = '{"max_speed",     0,  479,  255,   1,  482, 0};

    resetN       = 1'b0;
    launchReq    = 1'b0;
    initialSpeed = 9'sd0;
    initialX     = 11'sd0;
    initialY     = 11'sd0;
    startOfFrame = 1'b0;
    collision    = 1'b0;
    #12;
    check("rst_active",  int'(isActive), 0);
    check("rst_ack",     int'(launchAck), 0);
    check("rst_x",       int'(topLeftX), 0);
    check("rst_y",       int'(topLeftY), 0);
    check("rst_explode", int'(explodeActive), 0);
    resetN = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 11; v++) begin
      launch(vecs[v].x0, vecs[v].y0, vecs[v].spd);
      check({vecs[v].name, "_ack"},    int'(launchAck), 1);
      check({vecs[v].name, "_launch"}, int'(isActive), 1);
      check({vecs[v].name, "_y0"},     int'(topLeftY), vecs[v].y0);
      sb.push_back('{vecs[v].name, vecs[v].x0, vecs[v].exp_y, vecs[v].exp_act});
      sof(vecs[v].sofs);
      e = sb.pop_front();
      check({e.name, "_x"},      int'(topLeftX), e.x);
      check({e.name, "_y"},      int'(topLeftY), e.y);
      check({e.name, "_active"}, int'(isActive), e.act);
      check({e.name, "_ack_lo"}, int'(launchAck), 0);
      retire();
    end

    // Ack lasts exactly one cycle; a second launch edge in flight is ignored.
    launch(40, 300, -64);
    check("seqA_ack", int'(launchAck), 1);
    tick();
    check("seqA_ack_one_cycle", int'(launchAck), 0);
    sof(3);
    check("seqA_y3", int'(topLeftY), 297);
    launchReq = 1'b0;
    tick();
    launchReq = 1'b1;
    tick();
    check("seqA_relaunch_ack", int'(launchAck), 0);
    tick();
    check("seqA_relaunch_active", int'(isActive), 1);
    check("seqA_relaunch_y", int'(topLeftY), 297);

    // Collision together with a frame pulse: collision wins, Y frozen.
    collision    = 1'b1;
    startOfFrame = 1'b1;
    tick();
    collision    = 1'b0;
    startOfFrame = 1'b0;
    check("seqA_coll_active", int'(isActive), 0);
    check("seqA_coll_y", int'(topLeftY), 297);
`ifdef ROCKET_EXPLOSION_EN
    check("seqA_explode_on", int'(explodeActive), 1);
    launchReq = 1'b0;
    tick();
    launchReq = 1'b1;
    tick();
    check("seqA_explode_launch_ack", int'(launchAck), 0);
    sof(7);
    check("seqA_explode_7", int'(explodeActive), 1);
    check("seqA_explode_frozen_y", int'(topLeftY), 297);
    sof(1);
    check("seqA_explode_off", int'(explodeActive), 0);
    check("seqA_explode_idle", int'(isActive), 0);
`else
    check("seqA_explode_tied", int'(explodeActive), 0);
`endif
    // Collision while idle does nothing, and no launch was queued.
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    check("seqA_idle_coll", int'(isActive), 0);
    check("seqA_idle_ack", int'(launchAck), 0);

    // Reset in mid-flight, with launchReq held high through reset release.
    launch(123, 250, 0);
    sof(2);
    check("seqB_y", int'(topLeftY), 250);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("seqB_rst_active", int'(isActive), 0);
    check("seqB_rst_x", int'(topLeftX), 0);
    check("seqB_rst_y", int'(topLeftY), 0);
    check("seqB_rst_ack", int'(launchAck), 0);
    tick();
    resetN = 1'b1;
    tick();
    tick();
    check("seqB_held_active", int'(isActive), 0);
    check("seqB_held_ack", int'(launchAck), 0);
    launchReq = 1'b0;
    tick();
    launchReq = 1'b1;
    tick();
    check("seqB_relaunch_ack", int'(launchAck), 1);
    check("seqB_relaunch_active", int'(isActive), 1);
    check("seqB_relaunch_y", int'(topLeftY), 250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
